// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the RAM status encoding and the machine word.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and RAM signals around mem_arbiter.
// master: the arbiter's view (drives waits, loads and the RAM request). slave: the caches/RAM side.
interface mem_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;

  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between icache fills and dcache accesses; data has priority.
// Define ARB_STARVE_GUARD_EN to let an instruction in after STARVE_LIMIT data grants.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.master bus,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2
  } arb_state_e;

  arb_state_e state_q, state_d;

  // Handshake: a port requests by holding its enable; it is done in the one
  // cycle its wait is 0 (ramstate==ACCESS while granted). ERROR ends the grant
  // with wait still high, so the held request is simply arbitrated again.
  logic d_req;
  logic ram_done;
  logic ram_end;
  logic i_done;
  logic d_done;
  logic starve_hit;

  assign d_req    = bus.dREN | bus.dWEN;
  assign ram_done = (bus.ramstate == ACCESS);
  assign ram_end  = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);
  assign i_done   = (state_q == IGRANT) && ram_done;
  assign d_done   = (state_q == DGRANT) && ram_done;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;

  assign starve_hit = bus.iREN && (starve_q == CNT_MAX);

  always_comb begin
    starve_d = starve_q;
    if (i_done || ((state_q == IDLE) && !bus.iREN)) begin
      starve_d = '0;
    end else if (d_done && bus.iREN && (starve_q != CNT_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  localparam int unsigned unused_starve_limit = STARVE_LIMIT;
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req && !starve_hit) begin
          state_d = DGRANT;
        end else if (bus.iREN) begin
          state_d = IGRANT;
        end
      end
      IGRANT: begin
        if (!bus.iREN || ram_end) begin
          state_d = IDLE;
        end
      end
      DGRANT: begin
        if (!d_req || ram_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RAM request follows the live enables so a withdrawn request drops at once.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    case (state_q)
      IGRANT: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        bus.iwait   = !i_done;
      end
      DGRANT: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dwait    = !d_done;
      end
      default: ;
    endcase
  end

  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-by-cycle vector table plus reset and starvation sequences.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int unsigned STARVE_LIMIT = 2;
  localparam logic        N  = 1'b0;
  localparam logic        Y  = 1'b1;
  localparam logic [1:0]  SI = 2'd0;
  localparam logic [1:0]  SG = 2'd1;
  localparam logic [1:0]  SD = 2'd2;
  localparam word_t       W0 = 32'h0;

  typedef struct {
    logic       iren, dren, dwen;
    word_t      ia, da, ds, rl;
    ramstate_t  rs;
    logic [1:0] e_st;
    logic       e_iw, e_dw, e_ren, e_wen;
    word_t      e_addr, e_store;
  } vec_t;

  logic       CLK = 1'b0;
  logic       nRST;
  logic [1:0] state_o;
  int         n_checks = 0;
  int         n_errors = 0;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];

  mem_arbiter_if bus();

  mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .bus    (bus),
    .state_o(state_o)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic drive_idle();
    bus.iREN = N; bus.iaddr = W0;
    bus.dREN = N; bus.dWEN = N; bus.daddr = W0; bus.dstore = W0;
    bus.ramload = W0; bus.ramstate = FREE;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    drive_idle();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // driver
  task automatic add(input logic iren, dren, dwen, input word_t ia, da, ds, rl,
                     input ramstate_t rs, input logic [1:0] st,
                     input logic iw, dw, ren, wen, input word_t addr, store);
    vec_t t;
    t.iren = iren; t.dren = dren; t.dwen = dwen;
    t.ia = ia; t.da = da; t.ds = ds; t.rl = rl; t.rs = rs;
    t.e_st = st; t.e_iw = iw; t.e_dw = dw; t.e_ren = ren; t.e_wen = wen;
    t.e_addr = addr; t.e_store = store;
    vecs.push_back(t);
    if (!iw || !dw) exp_q.push_back(rl);
  endtask

  task automatic apply(input vec_t t);
    bus.iREN = t.iren; bus.iaddr = t.ia;
    bus.dREN = t.dren; bus.dWEN = t.dwen; bus.daddr = t.da; bus.dstore = t.ds;
    bus.ramload = t.rl; bus.ramstate = t.rs;
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_vec(input int k, input vec_t t);
    check($sformatf("v%0d.state", k),    32'(state_o),      32'(t.e_st));
    check($sformatf("v%0d.iwait", k),    32'(bus.iwait),    32'(t.e_iw));
    check($sformatf("v%0d.dwait", k),    32'(bus.dwait),    32'(t.e_dw));
    check($sformatf("v%0d.ramREN", k),   32'(bus.ramREN),   32'(t.e_ren));
    check($sformatf("v%0d.ramWEN", k),   32'(bus.ramWEN),   32'(t.e_wen));
    check($sformatf("v%0d.ramaddr", k),  bus.ramaddr,       t.e_addr);
    check($sformatf("v%0d.ramstore", k), bus.ramstore,      t.e_store);
    check($sformatf("v%0d.dload", k),    bus.dload,         t.rl);
    if (!bus.iwait || !bus.dwait) begin
      if (exp_q.size() == 0) begin
        check($sformatf("v%0d.extra_completion", k), 32'h1, 32'h0);
      end else if (!bus.iwait) begin
        check($sformatf("v%0d.iload", k), bus.iload, exp_q.pop_front());
      end else begin
        check($sformatf("v%0d.dload_sb", k), bus.dload, exp_q.pop_front());
      end
    end
  endtask

  initial begin
    logic [1:0] exp_g[6];
    logic [1:0] got_g[6];
    int         n_g;

    // reset values while nRST is held low
    nRST = 1'b0;
    drive_idle();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst.iwait",    32'(bus.iwait),  32'h1);
    check("rst.dwait",    32'(bus.dwait),  32'h1);
    check("rst.ramREN",   32'(bus.ramREN), 32'h0);
    check("rst.ramWEN",   32'(bus.ramWEN), 32'h0);
    check("rst.ramaddr",  bus.ramaddr,     32'h0);
    check("rst.ramstore", bus.ramstore,    32'h0);
    check("rst.state",    32'(state_o),    32'(SI));
    nRST = 1'b1;

    // one vector per cycle: iREN dREN dWEN iaddr daddr dstore ramload ramstate | state iwait dwait REN WEN addr store
    add(N,N,N, W0,W0,W0, W0,           FREE,   SI, Y,Y,N,N, W0,W0);
    add(Y,N,N, 32'h40,W0,W0, W0,       FREE,   SI, Y,Y,N,N, W0,W0);
    add(Y,N,N, 32'h40,W0,W0, 32'hDEADBEEF, ACCESS, SG, N,Y,Y,N, 32'h40,W0);
    add(N,N,N, 32'h40,W0,W0, 32'h11111111, FREE, SI, Y,Y,N,N, W0,W0);
    add(Y,N,Y, 32'h80,32'h100,32'h1234, W0, FREE, SI, Y,Y,N,N, W0,W0);
    add(Y,N,Y, 32'h80,32'h100,32'h1234, 32'h22222222, ACCESS, SD, Y,N,N,Y, 32'h100,32'h1234);
    add(Y,N,N, 32'h80,32'h100,32'h1234, W0, FREE, SI, Y,Y,N,N, W0,W0);
    add(Y,N,N, 32'h80,W0,W0, 32'h5555AAAA, ACCESS, SG, N,Y,Y,N, 32'h80,W0);
    add(N,Y,N, W0,32'h200,W0, W0,      FREE,   SI, Y,Y,N,N, W0,W0);
    for (int b = 0; b < 3; b++)
      add(N,Y,N, W0,32'h200,W0, 32'h33333333, BUSY, SD, Y,Y,Y,N, 32'h200,W0);
    add(N,Y,N, W0,32'h200,W0, 32'h0BADF00D, ACCESS, SD, Y,N,Y,N, 32'h200,W0);
    add(N,N,N, W0,W0,W0, W0,           FREE,   SI, Y,Y,N,N, W0,W0);
    add(N,Y,N, W0,32'h300,W0, W0,      FREE,   SI, Y,Y,N,N, W0,W0);
    add(N,Y,N, W0,32'h300,W0, 32'h44444444, ERROR, SD, Y,Y,Y,N, 32'h300,W0);
    add(N,Y,N, W0,32'h300,W0, W0,      FREE,   SI, Y,Y,N,N, W0,W0);
    add(N,Y,N, W0,32'h300,W0, 32'hCAFEF00D, ACCESS, SD, Y,N,Y,N, 32'h300,W0);
    add(N,N,N, W0,W0,W0, W0,           FREE,   SI, Y,Y,N,N, W0,W0);
    add(Y,N,N, 32'h44,W0,W0, W0,       FREE,   SI, Y,Y,N,N, W0,W0);
    add(N,N,N, 32'h44,W0,W0, W0,       BUSY,   SG, Y,Y,N,N, 32'h44,W0);
    add(N,N,N, 32'h44,W0,W0, W0,       FREE,   SI, Y,Y,N,N, W0,W0);
    add(N,Y,Y, W0,32'h10,32'h99, W0,   FREE,   SI, Y,Y,N,N, W0,W0);
    add(N,Y,Y, W0,32'h10,32'h99, W0,   BUSY,   SD, Y,Y,N,Y, 32'h10,32'h99);
    add(N,Y,Y, W0,32'h10,32'h99, 32'h66666666, ACCESS, SD, Y,N,N,Y, 32'h10,32'h99);
    add(N,N,N, W0,W0,W0, W0,           FREE,   SI, Y,Y,N,N, W0,W0);

    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge CLK); #1;
      apply(vecs[k]);
      @(negedge CLK);
      check_vec(k, vecs[k]);
    end
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);

    // reset asserted in the middle of a data write grant
    @(posedge CLK); #1;
    bus.dWEN = Y; bus.daddr = 32'h500; bus.dstore = 32'h77; bus.ramstate = BUSY;
    @(posedge CLK); #1;
    check("midrst.pre_ramWEN", 32'(bus.ramWEN), 32'h1);
    #2 nRST = 1'b0;
    #1;
    check("midrst.iwait",  32'(bus.iwait),  32'h1);
    check("midrst.dwait",  32'(bus.dwait),  32'h1);
    check("midrst.ramREN", 32'(bus.ramREN), 32'h0);
    check("midrst.ramWEN", 32'(bus.ramWEN), 32'h0);
    check("midrst.state",  32'(state_o),    32'(SI));
    drive_idle();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
    check("postrst.state",   32'(state_o),  32'(SI));
    check("postrst.ramaddr", bus.ramaddr,   32'h0);

    // continuous data and instruction demand with an always-ready RAM
`ifdef ARB_STARVE_GUARD_EN
    exp_g[0] = SD; exp_g[1] = SD; exp_g[2] = SG;
    exp_g[3] = SD; exp_g[4] = SD; exp_g[5] = SG;
`else
    for (int g = 0; g < 6; g++) exp_g[g] = SD;
`endif
    do_reset();
    @(posedge CLK); #1;
    bus.iREN = Y; bus.iaddr = 32'h8; bus.dREN = Y; bus.daddr = 32'hC;
    bus.ramstate = ACCESS; bus.ramload = 32'h12345678;
    n_g = 0;
    for (int c = 0; c < 40 && n_g < 6; c++) begin
      @(negedge CLK);
      if (state_o != SI) begin
        got_g[n_g] = state_o;
        n_g++;
      end
    end
    check("guard.grant_count", 32'(n_g), 32'd6);
    for (int g = 0; g < n_g; g++)
      check($sformatf("guard.grant%0d", g), 32'(got_g[g]), 32'(exp_g[g]));
    drive_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
